// File: rtl/writeback_stage_pkg.sv
// Shared MEM/WB encodings for the write-data select and HI/LO operation fields.
// The controller, MEM/WB register and writeback stage all import these codes.
package wb_defs;

  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_PC4 = 3'd2;
  localparam logic [2:0] WB_HI  = 3'd3;
  localparam logic [2:0] WB_LO  = 3'd4;
  localparam logic [2:0] WB_LUI = 3'd5;

  localparam logic [3:0] HL_NONE = 4'd0;
  localparam logic [3:0] HL_MULT = 4'd1;
  localparam logic [3:0] HL_MADD = 4'd2;
  localparam logic [3:0] HL_MSUB = 4'd3;
  localparam logic [3:0] HL_MTHI = 4'd4;
  localparam logic [3:0] HL_MTLO = 4'd5;

  // Codes above HL_MTLO are bubbles and do not count as retired work.
  function automatic logic hl_is_op(input logic [3:0] code);
    return (code >= HL_MULT) && (code <= HL_MTLO);
  endfunction

endpackage

// File: rtl/writeback_stage_hilo_unit.sv
// Architectural HI/LO register pair with the 64-bit madd/msub accumulator.
// Arithmetic wraps modulo 2^64; carry and borrow cross from LO into HI.
module hilo_unit
  import wb_defs::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  HiLoEnable,
  input  logic [63:0] Product,
  input  logic [31:0] ALUResult,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut
);

  logic [31:0] hi;
  logic [31:0] lo;
  logic [63:0] acc;
  logic [63:0] acc_sum;
  logic [63:0] acc_diff;

  assign acc      = {hi, lo};
  assign acc_sum  = acc + Product;
  assign acc_diff = acc - Product;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else begin
      case (HiLoEnable)
        HL_MULT: {hi, lo} <= Product;
        HL_MADD: {hi, lo} <= acc_sum;
        HL_MSUB: {hi, lo} <= acc_diff;
        HL_MTHI: hi <= ALUResult;
        HL_MTLO: lo <= ALUResult;
        default: ;
      endcase
    end
  end

  assign HiOut = hi;
  assign LoOut = lo;

endmodule

// File: rtl/writeback_stage.sv
// MIPS writeback stage: register-file write-data mux and enable, HI/LO pair,
// and a retired-instruction counter.
module writeback_stage
  import wb_defs::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData,
  input  logic [31:0] PCPlus4,
  input  logic [31:0] LUIValue,
  input  logic [63:0] Product,
  input  logic [2:0]  MemtoReg,
  input  logic        RegWrite,
  input  logic [4:0]  WriteReg,
  input  logic [3:0]  HiLoEnable,
  output logic [31:0] RFWriteData,
  output logic        RFWriteEn,
  output logic [4:0]  RFWriteReg,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic [31:0] RetireCount
);

  logic [31:0] hi_cur;
  logic [31:0] lo_cur;
  logic [31:0] retire_count;
  logic        retire_event;

  hilo_unit u_hilo (
    .Clk        (Clk),
    .Reset      (Reset),
    .HiLoEnable (HiLoEnable),
    .Product    (Product),
    .ALUResult  (ALUResult),
    .HiOut      (hi_cur),
    .LoOut      (lo_cur)
  );

  // HI/LO selects read the registered value, i.e. before this edge's update.
  always_comb begin
    RFWriteData = 32'd0;
    case (MemtoReg)
      WB_ALU:  RFWriteData = ALUResult;
      WB_MEM:  RFWriteData = ReadData;
      WB_PC4:  RFWriteData = PCPlus4;
      WB_HI:   RFWriteData = hi_cur;
      WB_LO:   RFWriteData = lo_cur;
      WB_LUI:  RFWriteData = LUIValue;
      default: RFWriteData = 32'd0;
    endcase
  end

  assign RFWriteEn    = RegWrite && (WriteReg != 5'd0) && (MemtoReg <= WB_LUI);
  assign RFWriteReg   = WriteReg;
  assign retire_event = RFWriteEn || hl_is_op(HiLoEnable);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      retire_count <= 32'd0;
    end else if (retire_event) begin
      retire_count <= retire_count + 32'd1;
    end
  end

  assign HiOut       = hi_cur;
  assign LoOut       = lo_cur;
  assign RetireCount = retire_count;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed plus randomized bench for writeback_stage against a behavioural
// model of HI/LO, write-data selection and the retire count.
module tb_writeback_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] ALUResult, ReadData, PCPlus4, LUIValue;
  logic [63:0] Product;
  logic [2:0]  MemtoReg;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [3:0]  HiLoEnable;
  logic [31:0] RFWriteData;
  logic        RFWriteEn;
  logic [4:0]  RFWriteReg;
  logic [31:0] HiOut, LoOut, RetireCount;

  int compared = 0;
  int mismatched = 0;

  // Behavioural model state
  logic [63:0] m_hilo;
  logic [31:0] m_count;

  writeback_stage dut (
    .Clk(Clk), .Reset(Reset), .ALUResult(ALUResult), .ReadData(ReadData),
    .PCPlus4(PCPlus4), .LUIValue(LUIValue), .Product(Product),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .HiLoEnable(HiLoEnable), .RFWriteData(RFWriteData), .RFWriteEn(RFWriteEn),
    .RFWriteReg(RFWriteReg), .HiOut(HiOut), .LoOut(LoOut),
    .RetireCount(RetireCount)
  );

  initial forever #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_wdata();
    logic [31:0] src [6];
    src[0] = ALUResult; src[1] = ReadData; src[2] = PCPlus4;
    src[3] = m_hilo[63:32]; src[4] = m_hilo[31:0]; src[5] = LUIValue;
    return (MemtoReg < 3'd6) ? src[MemtoReg] : 32'd0;
  endfunction

  function automatic logic exp_wen();
    return RegWrite && (WriteReg != 5'd0) && (MemtoReg < 3'd6);
  endfunction

  task automatic set_idle();
    Reset = 1'b0; ALUResult = 32'd0; ReadData = 32'd0; PCPlus4 = 32'd0;
    LUIValue = 32'd0; Product = 64'd0; MemtoReg = 3'd0; RegWrite = 1'b0;
    WriteReg = 5'd0; HiLoEnable = 4'd0;
  endtask

  // Inputs are already set at a negedge; check comb outputs, clock, check state.
  task automatic do_cycle();
    logic ev;
    #1;
    check("rf_wdata", {32'd0, RFWriteData}, {32'd0, exp_wdata()});
    check("rf_wen", {63'd0, RFWriteEn}, {63'd0, exp_wen()});
    check("rf_wreg", {59'd0, RFWriteReg}, {59'd0, WriteReg});
    ev = exp_wen() || (HiLoEnable >= 4'd1 && HiLoEnable <= 4'd5);
    @(posedge Clk);
    if (Reset) begin
      m_hilo = 64'd0;
      m_count = 32'd0;
    end else begin
      case (HiLoEnable)
        4'd1: m_hilo = Product;
        4'd2: m_hilo = m_hilo + Product;
        4'd3: m_hilo = m_hilo - Product;
        4'd4: m_hilo[63:32] = ALUResult;
        4'd5: m_hilo[31:0] = ALUResult;
        default: ;
      endcase
      if (ev) m_count = m_count + 32'd1;
    end
    @(negedge Clk);
    check("hi", {32'd0, HiOut}, {32'd0, m_hilo[63:32]});
    check("lo", {32'd0, LoOut}, {32'd0, m_hilo[31:0]});
    check("retire", {32'd0, RetireCount}, {32'd0, m_count});
  endtask

  task automatic reset_cycle();
    set_idle();
    Reset = 1'b1;
    do_cycle();
    Reset = 1'b0;
  endtask

  initial begin
    m_hilo = 64'd0;
    m_count = 32'd0;
    set_idle();
    @(negedge Clk);
    reset_cycle();
    reset_cycle();

    // 1. Reset wins over a same-cycle mult.
    set_idle(); HiLoEnable = 4'd4; ALUResult = 32'd5; do_cycle();
    check("pre_reset_hi", {32'd0, HiOut}, 64'd5);
    set_idle(); Reset = 1'b1; HiLoEnable = 4'd1; Product = 64'hFFFF_FFFF_0000_0001;
    do_cycle();
    check("reset_hi", {32'd0, HiOut}, 64'd0);
    check("reset_lo", {32'd0, LoOut}, 64'd0);
    check("reset_count", {32'd0, RetireCount}, 64'd0);

    // 2. Write-data select sweep.
    for (int s = 0; s < 8; s++) begin
      set_idle(); RegWrite = 1'b1; WriteReg = 5'd8; MemtoReg = 3'(s);
      ALUResult = 32'hA000_0001; ReadData = 32'hB000_0002;
      PCPlus4 = 32'hC000_0003; LUIValue = 32'hD000_0004;
      do_cycle();
    end
    set_idle(); RegWrite = 1'b1; WriteReg = 5'd0; MemtoReg = 3'd0; ALUResult = 32'h1;
    #1; check("wen_r0", {63'd0, RFWriteEn}, 64'd0);
    do_cycle();
    set_idle(); RegWrite = 1'b1; WriteReg = 5'd8; MemtoReg = 3'd6;
    #1; check("wen_sel6", {63'd0, RFWriteEn}, 64'd0);
    do_cycle();

    // 3. mult then madd: carry crosses into HI.
    set_idle(); HiLoEnable = 4'd1; Product = 64'h0000_0000_FFFF_FFFF; do_cycle();
    set_idle(); HiLoEnable = 4'd2; Product = 64'd1; do_cycle();
    check("madd_carry", {HiOut, LoOut}, 64'h0000_0001_0000_0000);
    set_idle(); RegWrite = 1'b1; WriteReg = 5'd3; MemtoReg = 3'd3; #1;
    check("mfhi_after_madd", {32'd0, RFWriteData}, 64'd1);
    do_cycle();

    // 4. msub underflow from zero.
    reset_cycle();
    set_idle(); HiLoEnable = 4'd3; Product = 64'd1; do_cycle();
    check("msub_underflow", {HiOut, LoOut}, 64'hFFFF_FFFF_FFFF_FFFF);

    // 5. mthi with same-edge mfhi, then mtlo.
    set_idle(); HiLoEnable = 4'd4; ALUResult = 32'hDEAD_BEEF;
    RegWrite = 1'b1; WriteReg = 5'd9; MemtoReg = 3'd3; #1;
    check("mfhi_same_edge", {32'd0, RFWriteData}, 64'hFFFF_FFFF);
    do_cycle();
    set_idle(); HiLoEnable = 4'd5; ALUResult = 32'h1234_5678; do_cycle();
    check("mthi_mtlo", {HiOut, LoOut}, 64'hDEAD_BEEF_1234_5678);

    // 6. Retire count: 10 qualifying, 4 bubbles.
    reset_cycle();
    for (int i = 0; i < 14; i++) begin
      set_idle();
      case (i % 7)
        0, 2, 4: begin RegWrite = 1'b1; WriteReg = 5'(1 + i); end
        1, 5:    HiLoEnable = 4'(4 + (i % 2));
        3:       begin HiLoEnable = 4'(6 + i); RegWrite = 1'b1; WriteReg = 5'd0; end
        default: begin RegWrite = 1'b1; WriteReg = 5'd4; MemtoReg = 3'd7; end
      endcase
      ALUResult = $urandom;
      do_cycle();
    end
    check("retire_ten", {32'd0, RetireCount}, 64'd10);

    force dut.retire_count = 32'hFFFF_FFFF;
    #1 release dut.retire_count;
    m_count = 32'hFFFF_FFFF;
    check("retire_preload", {32'd0, RetireCount}, 64'hFFFF_FFFF);
    set_idle(); HiLoEnable = 4'd5; ALUResult = 32'h77; do_cycle();
    check("retire_wrap", {32'd0, RetireCount}, 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_idle();
      Reset = ($urandom_range(0, 49) == 0);
      ALUResult = $urandom; ReadData = $urandom; PCPlus4 = $urandom;
      LUIValue = $urandom; Product = {$urandom, $urandom};
      MemtoReg = 3'($urandom_range(0, 7));
      RegWrite = 1'($urandom_range(0, 1));
      WriteReg = 5'($urandom_range(0, 31));
      HiLoEnable = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(6, 15))
                                               : 4'($urandom_range(0, 5));
      do_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the MIPS datapath and the consumer of every field the MEM/WB register holds. It selects the register-file write data, gates the register-file write enable, and owns the architectural HI/LO register pair. HI/LO updates cover mult, madd, msub, mthi and mtlo. It also keeps a retired-instruction counter for the performance bench.

## Interface
- No parameters. All widths are fixed by the 32-bit datapath.
- Clk  in  1  rising-edge clock; one clock for the whole block.
- Reset  in  1  synchronous, active-high.
- ALUResult  in  32  registered ALU result from MEM/WB.
- ReadData  in  32  registered load data.
- PCPlus4  in  32  registered link address.
- LUIValue  in  32  registered upper-immediate value.
- Product  in  64  registered multiplier product, {hi, lo}.
- MemtoReg  in  3  write-data select.
- RegWrite  in  1  register-write request.
- WriteReg  in  5  destination register number.
- HiLoEnable  in  4  HI/LO operation code.
- RFWriteData  out  32  data to the register-file write port.
- RFWriteEn  out  1  qualified register-file write enable.
- RFWriteReg  out  5  equals WriteReg.
- HiOut  out  32  current HI, for the forwarding unit.
- LoOut  out  32  current LO, for the forwarding unit.
- RetireCount  out  32  instructions retired since reset.

## Operation
**Write-data select, MemtoReg (combinational)**
- 0: ALUResult.
- 1: ReadData.
- 2: PCPlus4.
- 3: HI.
- 4: LO.
- 5: LUIValue.
- 6–7: reserved. RFWriteData = 0 and RFWriteEn is forced to 0.
- Codes 3 and 4 return the HI/LO value *before* any update on the same edge.

**Register-file write enable**
- RFWriteEn = RegWrite && WriteReg != 0 && MemtoReg <= 5.

**HI/LO update on HiLoEnable (applied at the clock edge)**
- 0: hold.
- 1 (mult/multu): {HI,LO} <= Product.
- 2 (madd): {HI,LO} <= {HI,LO} + Product.
- 3 (msub): {HI,LO} <= {HI,LO} − Product.
- 4 (mthi): HI <= ALUResult; LO holds.
- 5 (mtlo): LO <= ALUResult; HI holds.
- 6–15: hold. These are treated as bubbles.
- madd/msub arithmetic is 64-bit, modulo 2^64. The carry/borrow crosses from LO into HI; overflow is discarded and no flag exists.

**Retire counter**
- Increments by 1 each cycle in which RFWriteEn = 1 or HiLoEnable is 1–5.
- Wraps 0xFFFFFFFF → 0.

## Timing
- RFWriteData, RFWriteEn and RFWriteReg are purely combinational from the inputs. Their latency is 0 within the WB cycle; the register file commits at its own rising edge.
- HI, LO and RetireCount are registered. A new value is visible on HiOut, LoOut and RetireCount one cycle after the qualifying cycle.
- Back-to-back cases:
  - madd followed by mfhi: the mfhi sees the madd result.
  - madd in cycle n and madd in cycle n+1: the second accumulates on the first.
- Reset:
  - Values: HI = LO = 0, RetireCount = 0.
  - Priority: Reset wins over any same-cycle HiLoEnable or retire event.
  - Reset asserted mid-accumulation discards the partial sum.
  - The combinational outputs are not gated by Reset.
- The upstream MEM/WB register powers up with zeros, so the initial bubble has RegWrite = 0 and HiLoEnable = 0.

## Structure
- Shared package / include `wb_defs` holds:
  - MemtoReg codes: WB_ALU, WB_MEM, WB_PC4, WB_HI, WB_LO, WB_LUI.
  - HiLoEnable codes: HL_NONE, HL_MULT, HL_MADD, HL_MSUB, HL_MTHI, HL_MTLO.
  - The same codes are to be used by the controller and by MEM/WB.
- One natural sub-module, `hilo_unit`: the HI/LO register pair and its 64-bit add/subtract. Its ports are Clk, Reset, HiLoEnable, Product, ALUResult, HiOut and LoOut.
- The write-data mux and the retire counter stay in the top level.

## Test plan
1. **Reset behaviour.** Set HI = 5, then assert Reset for one cycle with HiLoEnable = 1, Product = 0xFFFF_FFFF_0000_0001.
   - Expected: HiOut = LoOut = 0 and RetireCount = 0 on the next cycle.
2. **Write-data select.** Sweep MemtoReg 0–5 with RegWrite = 1, WriteReg = 8 and distinct input values.
   - Expected: RFWriteData matches each selected source and RFWriteEn = 1.
   - MemtoReg = 6 → RFWriteEn = 0. WriteReg = 0 → RFWriteEn = 0.
3. **mult then madd.** Cycle 1: mult with Product = 0x0000_0000_FFFF_FFFF. Cycle 2: madd with Product = 1.
   - Expected: {HI,LO} = 0x0000_0001_0000_0000, i.e. the carry crosses into HI.
4. **msub underflow.** With {HI,LO} = 0, apply msub with Product = 1.
   - Expected: HI = LO = 0xFFFF_FFFF.
5. **mthi, mtlo and same-edge read.** mthi with ALUResult = 0xDEAD_BEEF, then mtlo with ALUResult = 0x1234_5678.
   - Expected: HI = 0xDEAD_BEEF and LO = 0x1234_5678.
   - MemtoReg = 3 in the mthi cycle itself returns the old HI.
6. **Retire counter.** Drive a mix of 10 qualifying and 4 bubble cycles.
   - Expected: RetireCount = 10.
   - Force the count to 0xFFFF_FFFF with one more qualifying cycle → the count wraps to 0.
